// File: rtl/pattern_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_seq_pkg
//  Description : Shared definitions for the pattern sequencer. Holds the
//                sequencing mode codes, the FSM state encoding and the
//                default table pattern loaded at reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package pattern_seq_pkg;

    // Sequencing modes; the reserved code behaves like wrap.
    localparam logic [1:0] c_MODE_WRAP     = 2'b00;
    localparam logic [1:0] c_MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] c_MODE_PINGPONG = 2'b10;
    localparam logic [1:0] c_MODE_RSVD     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_PATTERN_LEN = 7;
    localparam logic [7:0] c_DEFAULT_PATTERN [c_PATTERN_LEN] = '{
        8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'h0B, 8'h8D
    };

    // Reset value of table entry idx; entries beyond the pattern are zero.
    function automatic logic [7:0] default_entry(input int idx);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < c_PATTERN_LEN; k++) begin
            if (k == idx) begin
                v = c_DEFAULT_PATTERN[k];
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_table.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_table
//  Description : DEPTH x DATA_W register file. Reset loads the default
//                pattern; one synchronous write port, one combinational
//                read port (reads return the pre-write contents).
//  Ports       : clk, reset_n      - clock, synchronous active-low reset
//                i_wr_en/addr/data - write port (out-of-range addr ignored)
//                i_rd_addr         - read address
//                o_rd_data         - read data (current stored value)
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_table
    import pattern_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem_q [DEPTH];
    logic [DATA_W-1:0] w_mem_d [DEPTH];

    // Address decode only matches existing entries, so writes to
    // addresses >= DEPTH fall through without effect.
    always_comb begin
        w_mem_d = r_mem_q;
        if (i_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_wr_addr == AW'(i)) begin
                    w_mem_d[i] = i_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= DATA_W'(default_entry(i));
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_addr == AW'(i)) begin
                o_rd_data = r_mem_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_sequencer
//  Description : Plays words out of a writable pattern table in wrap,
//                one-shot or ping-pong order with a valid/ready handshake.
//  Ports       : clk, reset_n            - clock, synchronous active-low reset
//                enable                  - advance qualifier
//                start / stop            - begin / abort a run
//                mode, cfg_last          - order and last index (latched)
//                wr_en, wr_addr, wr_data - table write port
//                data, out_valid         - registered word and its valid
//                out_ready               - consumer accept
//                busy, done              - run active / one-shot finished
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 7,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [AW-1:0]     cfg_last,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [AW-1:0] c_MAX_IDX = AW'(DEPTH - 1);

    state_t            r_state_q,    w_state_d;
    logic [AW-1:0]     r_index_q,    w_index_d;
    logic              r_dir_down_q, w_dir_down_d;
    logic [1:0]        r_mode_q,     w_mode_d;
    logic [AW-1:0]     r_last_q,     w_last_d;
    logic [DATA_W-1:0] r_data_q,     w_data_d;
    logic              w_load;
    logic              w_xfer;
    logic [DATA_W-1:0] w_rd_data;

    // The table is read at the next index so the word lands in the output
    // register on the same edge as the index update.
    pattern_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_table (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_index_d),
        .o_rd_data (w_rd_data)
    );

    assign w_xfer = (r_state_q == ST_RUN) && enable && out_ready;

    always_comb begin
        w_state_d    = r_state_q;
        w_index_d    = r_index_q;
        w_dir_down_d = r_dir_down_q;
        w_mode_d     = r_mode_q;
        w_last_d     = r_last_q;
        w_load       = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d    = ST_RUN;
                    w_mode_d     = mode;
                    w_last_d     = (cfg_last > c_MAX_IDX) ? c_MAX_IDX : cfg_last;
                    w_index_d    = '0;
                    w_dir_down_d = 1'b0;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                // stop wins over a transfer in the same cycle
                if (stop) begin
                    w_state_d = ST_IDLE;
                end else if (w_xfer) begin
                    case (r_mode_q)
                        c_MODE_ONESHOT: begin
                            if (r_index_q == r_last_q) begin
                                w_state_d = ST_DONE;
                            end else begin
                                w_index_d = r_index_q + AW'(1);
                                w_load    = 1'b1;
                            end
                        end
                        c_MODE_PINGPONG: begin
                            w_load = 1'b1;
                            if (r_last_q == '0) begin
                                w_index_d = '0;
                            end else if (!r_dir_down_q) begin
                                if (r_index_q == r_last_q) begin
                                    w_dir_down_d = 1'b1;
                                    w_index_d    = r_index_q - AW'(1);
                                end else begin
                                    w_index_d = r_index_q + AW'(1);
                                end
                            end else begin
                                if (r_index_q == '0) begin
                                    w_dir_down_d = 1'b0;
                                    w_index_d    = AW'(1);
                                end else begin
                                    w_index_d = r_index_q - AW'(1);
                                end
                            end
                        end
                        c_MODE_WRAP, c_MODE_RSVD: begin
                            w_load    = 1'b1;
                            w_index_d = (r_index_q == r_last_q) ? '0 : r_index_q + AW'(1);
                        end
                        default: begin
                            w_load    = 1'b1;
                            w_index_d = (r_index_q == r_last_q) ? '0 : r_index_q + AW'(1);
                        end
                    endcase
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    assign w_data_d = w_load ? w_rd_data : r_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q    <= ST_IDLE;
            r_index_q    <= '0;
            r_dir_down_q <= 1'b0;
            r_mode_q     <= c_MODE_WRAP;
            r_last_q     <= '0;
            r_data_q     <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_index_q    <= w_index_d;
            r_dir_down_q <= w_dir_down_d;
            r_mode_q     <= w_mode_d;
            r_last_q     <= w_last_d;
            r_data_q     <= w_data_d;
        end
    end

    assign data      = r_data_q;
    assign out_valid = (r_state_q == ST_RUN) && enable;
    assign busy      = (r_state_q == ST_RUN);
    assign done      = (r_state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_sequencer
//  Description : Self-checking bench for pattern_sequencer: directed
//                scenarios with literal expectations followed by random
//                traffic compared against a sequence-position model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 7;
    localparam int AW     = 3;

    localparam logic [7:0] c_DEF [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'h0B, 8'h8D, 8'h00};
    localparam logic [7:0] c_WRAP_EXP [7] = '{8'hBC, 8'hE2, 8'h78, 8'hFF, 8'h0B, 8'h8D, 8'hAF};
    localparam logic [7:0] c_PP_EXP [5] = '{8'hBC, 8'hE2, 8'hBC, 8'hAF, 8'hBC};

    logic              clk = 1'b0;
    logic              reset_n, enable, start, stop, wr_en, out_ready;
    logic [1:0]        mode;
    logic [AW-1:0]     cfg_last, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] data;
    logic              out_valid, busy, done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pattern_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .cfg_last  (cfg_last),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The run is a count of completed beats p; the table index for beat p
    // follows directly from the mode's ordering rule.
    logic [7:0] m_tab [8];
    int         m_state;   // 0 idle, 1 running, 2 done pulse
    int         m_p;
    int         m_last;
    logic [1:0] m_mode;
    logic [7:0] m_data;

    function automatic int seq_idx(input int p, input logic [1:0] md, input int last);
        int k;
        if (md == 2'b10) begin
            if (last == 0) return 0;
            k = p % (2 * last);
            return (k <= last) ? k : 2 * last - k;
        end
        if (md == 2'b01) return p;
        return p % (last + 1);
    endfunction

    always @(posedge clk) begin : model
        int np;
        if (!reset_n) begin
            m_state <= 0;
            m_p     <= 0;
            m_last  <= 0;
            m_mode  <= 2'b00;
            m_data  <= 8'h00;
            for (int i = 0; i < 8; i++) m_tab[i] <= c_DEF[i];
        end else begin
            if (m_state == 0 && start) begin
                m_state <= 1;
                m_mode  <= mode;
                m_last  <= (int'(cfg_last) > DEPTH - 1) ? DEPTH - 1 : int'(cfg_last);
                m_p     <= 0;
                m_data  <= m_tab[0];
            end else if (m_state == 1 && stop) begin
                m_state <= 0;
            end else if (m_state == 1 && enable && out_ready) begin
                np = m_p + 1;
                if (m_mode == 2'b01 && np > m_last) begin
                    m_state <= 2;
                end else begin
                    m_p    <= np;
                    m_data <= m_tab[seq_idx(np, m_mode, m_last)];
                end
            end else if (m_state == 2) begin
                m_state <= 0;
            end
            if (wr_en && int'(wr_addr) < DEPTH) m_tab[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_data",  32'(data),  32'(m_data));
            cmp("m_valid", 32'(out_valid), 32'(m_state == 1 && enable));
            cmp("m_busy",  32'(busy),  32'(m_state == 1));
            cmp("m_done",  32'(done),  32'(m_state == 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [1:0] md, input logic [AW-1:0] lst);
        mode = md; cfg_last = lst; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
        cfg_last = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
        step(); step();
        chk_en = 1'b1;
        cmp("rst_data", 32'(data), 32'h00);
        cmp("rst_valid", 32'(out_valid), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_done", 32'(done), 0);
        reset_n = 1'b1;

        // wrap, last=6
        go(2'b00, 3'd6);
        cmp("wrap_first", 32'(data), 32'hAF);
        cmp("wrap_valid", 32'(out_valid), 1);
        for (int i = 0; i < 7; i++) begin
            step();
            cmp("wrap_seq", 32'(data), 32'(c_WRAP_EXP[i]));
        end
        halt();
        cmp("stop_hold", 32'(data), 32'hAF);
        cmp("stop_valid", 32'(out_valid), 0);

        // one-shot, last=2
        go(2'b01, 3'd2);
        cmp("os_0", 32'(data), 32'hAF);
        step(); cmp("os_1", 32'(data), 32'hBC);
        step(); cmp("os_2", 32'(data), 32'hE2);
        step();
        cmp("os_done", 32'(done), 1);
        cmp("os_busy", 32'(busy), 0);
        cmp("os_valid", 32'(out_valid), 0);
        step();
        cmp("os_done_clr", 32'(done), 0);
        cmp("os_idle_valid", 32'(out_valid), 0);

        // ping-pong, last=2 then last=0
        go(2'b10, 3'd2);
        cmp("pp_0", 32'(data), 32'hAF);
        for (int i = 0; i < 5; i++) begin
            step();
            cmp("pp_seq", 32'(data), 32'(c_PP_EXP[i]));
        end
        halt();
        go(2'b10, 3'd0);
        for (int i = 0; i < 4; i++) begin
            cmp("pp0_data", 32'(data), 32'hAF);
            cmp("pp0_valid", 32'(out_valid), 1);
            step();
        end
        halt();

        // back-pressure via out_ready, then via enable
        go(2'b00, 3'd6);
        step(); cmp("rdy_bc", 32'(data), 32'hBC);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin step(); cmp("rdy_hold", 32'(data), 32'hBC); end
        out_ready = 1'b1;
        step(); cmp("rdy_next", 32'(data), 32'hE2);
        halt();
        go(2'b00, 3'd6);
        step(); cmp("en_bc", 32'(data), 32'hBC);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("en_hold", 32'(data), 32'hBC);
            cmp("en_valid", 32'(out_valid), 0);
        end
        enable = 1'b1;
        step(); cmp("en_next", 32'(data), 32'hE2);
        halt();

        // table write while entry 1 is presented, then out-of-range write
        go(2'b00, 3'd6);
        step();
        out_ready = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        cmp("wr_hold", 32'(data), 32'hBC);
        out_ready = 1'b1;
        step(); cmp("wr_next", 32'(data), 32'hE2);
        for (int i = 0; i < 5; i++) step();
        cmp("wr_wrap0", 32'(data), 32'hAF);
        step(); cmp("wr_new", 32'(data), 32'h55);
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 7; i++) step();
        cmp("wr_oob", 32'(data), 32'hE2);
        halt();

        // reset in the middle of a run
        go(2'b00, 3'd6);
        step(); step(); step();
        cmp("mid_idx3", 32'(data), 32'h78);
        reset_n = 1'b0;
        step();
        cmp("mid_rst_data", 32'(data), 32'h00);
        cmp("mid_rst_valid", 32'(out_valid), 0);
        cmp("mid_rst_done", 32'(done), 0);
        reset_n = 1'b1;
        go(2'b00, 3'd6);
        cmp("restart_0", 32'(data), 32'hAF);
        step(); cmp("restart_1", 32'(data), 32'hBC);
        halt();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            mode      = 2'($urandom_range(0, 3));
            cfg_last  = AW'($urandom_range(0, 7));
            enable    = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wr_en     = ($urandom_range(0, 9) == 0);
            wr_addr   = AW'($urandom_range(0, 7));
            wr_data   = 8'($urandom);
            reset_n   = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
